// File: rtl/vmx_axis_fifo_writer_if.sv
// AXI4-Stream handshake bundle between the DMA stream master and the VMX FIFO writer.
`timescale 1ns/1ps
interface vmx_axis_fifo_writer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tstrb, input tlast, input tvalid, output tready);
endinterface

// File: rtl/vmx_axis_fifo_writer.sv
// AXI4-Stream slave feeding the VMX input FIFO through a 2-entry skid buffer at one beat per clock.
// Optional packet counter on PKT_COUNT enabled by defining VMX_PKT_STATS_EN.
`timescale 1ns/1ps
module vmx_axis_fifo_writer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_MAX_BEATS          = 256,
    parameter bit C_STRB_MASK          = 1'b1
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    vmx_axis_fifo_writer_if.slave           s_axis,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] FIFO_DATA,
    output logic                            FIFO_LAST,
    output logic                            FIFO_WREN,
    input  logic                            FIFO_FULL,
    output logic                            ERR_OVERLEN,
    input  logic                            ERR_CLR,
    output logic [15:0]                     PKT_COUNT
);
    localparam int W      = C_S_AXIS_TDATA_WIDTH;
    localparam int STRB_W = W / 8;
    localparam logic [15:0] LAST_IDX = 16'(C_MAX_BEATS - 1);

    function automatic logic [W-1:0] mask_bytes(input logic [W-1:0] d, input logic [STRB_W-1:0] s);
        logic [W-1:0] r;
        r = d;
        if (C_STRB_MASK) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (!s[i]) r[8*i +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

    logic          ready_en;
    logic [1:0]    occ;
    logic [15:0]   beat_cnt;
    logic [W-1:0]  head_data, tail_data;
    logic          head_last, tail_last;
    logic          push, pop, at_limit, in_last, overlen;
    logic [W-1:0]  in_data;

    // Ready is a pure decode of flops so TVALID/FIFO_FULL never reach TREADY combinationally.
    assign s_axis.tready = ready_en && (occ != 2'd2);
    assign FIFO_WREN     = (occ != 2'd0) && !FIFO_FULL;
    assign FIFO_DATA     = (occ != 2'd0) ? head_data : '0;
    assign FIFO_LAST     = (occ != 2'd0) && head_last;

    assign push     = s_axis.tvalid && s_axis.tready;
    assign pop      = FIFO_WREN;
    assign at_limit = (beat_cnt == LAST_IDX);
    assign in_last  = s_axis.tlast || at_limit;
    assign overlen  = push && at_limit && !s_axis.tlast;
    assign in_data  = mask_bytes(s_axis.tdata, s_axis.tstrb);

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            ready_en    <= 1'b0;
            occ         <= 2'd0;
            beat_cnt    <= 16'd0;
            ERR_OVERLEN <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (push) beat_cnt <= in_last ? 16'd0 : beat_cnt + 16'd1;
            if (overlen)      ERR_OVERLEN <= 1'b1;
            else if (ERR_CLR) ERR_OVERLEN <= 1'b0;
        end
    end

    // Entry storage is not reset; the occupancy gate on the outputs hides stale contents.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (pop && occ == 2'd2) begin
            head_data <= tail_data;
            head_last <= tail_last;
        end
        if (push) begin
            if (occ == 2'd0 || pop) begin
                head_data <= in_data;
                head_last <= in_last;
            end else begin
                tail_data <= in_data;
                tail_last <= in_last;
            end
        end
    end

`ifdef VMX_PKT_STATS_EN
    logic [15:0] pkt_cnt;
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN)             pkt_cnt <= 16'd0;
        else if (FIFO_WREN && FIFO_LAST) pkt_cnt <= pkt_cnt + 16'd1;
    end
    assign PKT_COUNT = pkt_cnt;
`else
    assign PKT_COUNT = 16'h0000;
`endif
endmodule

// File: tb/tb_vmx_axis_fifo_writer.sv
// Bench for vmx_axis_fifo_writer: two instances (byte masking on/off) against a queue-based reference model.
`timescale 1ns/1ps
module tb_vmx_axis_fifo_writer;
    localparam int W    = 32;
    localparam int MAXB = 4;
`ifdef VMX_PKT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] r;
        logic         l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] tdata = '0;
    logic [3:0]   tstrb = 4'hF;
    logic         tlast = 1'b0, tvalid = 1'b0, full = 1'b0, err_clr = 1'b0;
    int           full_mode = 0;
    int           full_hold = 0;
    bit           clr_rand = 1'b0;

    vmx_axis_fifo_writer_if #(.DATA_W(W)) ifa ();
    vmx_axis_fifo_writer_if #(.DATA_W(W)) ifb ();
    assign ifa.tdata = tdata;  assign ifb.tdata = tdata;
    assign ifa.tstrb = tstrb;  assign ifb.tstrb = tstrb;
    assign ifa.tlast = tlast;  assign ifb.tlast = tlast;
    assign ifa.tvalid = tvalid; assign ifb.tvalid = tvalid;

    logic [W-1:0] data_a, data_b;
    logic         last_a, last_b, wren_a, wren_b, err_a, err_b;
    logic [15:0]  pkt_a, pkt_b;

    vmx_axis_fifo_writer #(.C_S_AXIS_TDATA_WIDTH(W), .C_MAX_BEATS(MAXB), .C_STRB_MASK(1'b1)) dut_a (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .s_axis(ifa.slave),
        .FIFO_DATA(data_a), .FIFO_LAST(last_a), .FIFO_WREN(wren_a), .FIFO_FULL(full),
        .ERR_OVERLEN(err_a), .ERR_CLR(err_clr), .PKT_COUNT(pkt_a));

    vmx_axis_fifo_writer #(.C_S_AXIS_TDATA_WIDTH(W), .C_MAX_BEATS(MAXB), .C_STRB_MASK(1'b0)) dut_b (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .s_axis(ifb.slave),
        .FIFO_DATA(data_b), .FIFO_LAST(last_b), .FIFO_WREN(wren_b), .FIFO_FULL(full),
        .ERR_OVERLEN(err_b), .ERR_CLR(err_clr), .PKT_COUNT(pkt_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of written-but-not-drained beats, packet beat index, sticky error.
    exp_t        q[$];
    exp_t        e;
    int          beats_m = 0;
    int          cyc_m = 0;
    logic        err_m = 1'b0;
    logic [15:0] pkt_m = 16'd0;
    logic        exp_rdy, exp_wr, acc_m, lst_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_tready", 32'(ifa.tready), 32'd0);
            check("rst_wren", 32'(wren_a), 32'd0);
            check("rst_err", 32'(err_a), 32'd0);
            check("rst_pkt", 32'(pkt_a), 32'd0);
            q.delete();
            beats_m = 0; cyc_m = 0; err_m = 1'b0; pkt_m = 16'd0;
        end else begin
            exp_rdy = (cyc_m >= 1) && (q.size() < 2);
            exp_wr  = (q.size() != 0) && !full;
            check("tready_a", 32'(ifa.tready), 32'(exp_rdy));
            check("tready_b", 32'(ifb.tready), 32'(exp_rdy));
            check("wren_a", 32'(wren_a), 32'(exp_wr));
            check("wren_b", 32'(wren_b), 32'(exp_wr));
            check("err_a", 32'(err_a), 32'(err_m));
            check("err_b", 32'(err_b), 32'(err_m));
            check("pkt_a", 32'(pkt_a), STATS ? 32'(pkt_m) : 32'd0);
            if (q.size() == 0) begin
                check("empty_data_a", data_a, 32'd0);
                check("empty_last_a", 32'(last_a), 32'd0);
                check("empty_data_b", data_b, 32'd0);
            end
            if (exp_wr) begin
                e = q.pop_front();
                check("data_a", data_a, e.m);
                check("data_b", data_b, e.r);
                check("last_a", 32'(last_a), 32'(e.l));
                check("last_b", 32'(last_b), 32'(e.l));
                if (e.l) pkt_m = pkt_m + 16'd1;
            end
            acc_m = tvalid && exp_rdy;
            if (acc_m) begin
                lst_m = tlast || (beats_m == MAXB - 1);
                e.m = tdata & {{8{tstrb[3]}}, {8{tstrb[2]}}, {8{tstrb[1]}}, {8{tstrb[0]}}};
                e.r = tdata;
                e.l = lst_m;
                q.push_back(e);
                if (!tlast && beats_m == MAXB - 1) err_m = 1'b1;
                else if (err_clr)                  err_m = 1'b0;
                beats_m = lst_m ? 0 : beats_m + 1;
            end else if (err_clr) begin
                err_m = 1'b0;
            end
            if (cyc_m < 2) cyc_m++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (full_hold > 0) begin
            full_hold--;
            if (full_hold == 0) full_mode = 0;
        end
        case (full_mode)
            1:       full = 1'b1;
            2:       full = ($urandom_range(0, 3) == 0);
            default: full = 1'b0;
        endcase
        if (clr_rand) err_clr = ($urandom_range(0, 15) == 0);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [3:0] s, input logic l);
        logic acc;
        int   n;
        tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = ifa.tready;
            tick();
            n++;
        end
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
        tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        @(negedge clk);
        check("drain_idle", 32'(wren_a), 32'd0);
        tick();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_after_clr", 32'(err_a), 32'd0);
        tick();
    endtask

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release with a beat already offered.
        tvalid = 1'b1; tdata = 32'hA0; tstrb = 4'hF;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(32'hA0 + 32'(i), 4'hF, i == 7);
        drain();
        pulse_clr();

        // Byte-strobe masking.
        send(32'h1122_3344, 4'b0101, 1'b1);
        send(32'hDEAD_BEEF, 4'b1010, 1'b1);
        drain();

        // Downstream full: skid fills to two, then holds off the master.
        full_mode = 1; full_hold = 5;
        tick();
        send(32'h300, 4'hF, 1'b0);
        send(32'h301, 4'hF, 1'b0);
        @(negedge clk);
        check("t3_tready_full", 32'(ifa.tready), 32'd0);
        send(32'h302, 4'hF, 1'b1);
        send(32'h303, 4'hF, 1'b0);
        send(32'h304, 4'hF, 1'b1);
        drain();

        // Over-length packet: 6 beats, TLAST only on the last.
        @(negedge clk);
        check("t4_err_pre", 32'(err_a), 32'd0);
        for (int i = 0; i < 6; i++) send(32'h400 + 32'(i), 4'hF, i == 5);
        drain();
        @(negedge clk);
        check("t4_err_set", 32'(err_a), 32'd1);
        pulse_clr();

        // Reset mid-packet with the buffer full.
        for (int i = 0; i < 5; i++) send(32'h500 + 32'(i), 4'hF, 1'b0);
        full_mode = 1;
        tick();
        send(32'h505, 4'hF, 1'b0);
        send(32'h506, 4'hF, 1'b0);
        tdata = 32'h507; tvalid = 1'b1; full = 1'b0; full_mode = 0;
        @(negedge clk);
        check("t5_err_before", 32'(err_a), 32'd1);
        check("t5_tready_before", 32'(ifa.tready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tready_rst", 32'(ifa.tready), 32'd0);
        check("t5_wren_rst", 32'(wren_a), 32'd0);
        check("t5_err_rst", 32'(err_a), 32'd0);
        tvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send(32'h600 + 32'(i), 4'hF, i == 2);
        drain();

        // Randomized traffic with random back-pressure and error clears.
        full_mode = 2; clr_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            send($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
        end
        full_mode = 0; clr_rand = 1'b0; err_clr = 1'b0;
        drain();

        // Packet counter wrap.
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
`ifdef VMX_PKT_STATS_EN
        for (int i = 0; i < 65535; i++) send(32'(i), 4'hF, 1'b1);
`else
        for (int i = 0; i < 20; i++) send(32'(i), 4'hF, 1'b1);
`endif
        send(32'h7000, 4'hF, 1'b1);
        send(32'h7001, 4'hF, 1'b1);
        drain();
        @(negedge clk);
        check("pkt_final", 32'(pkt_a), STATS ? 32'd1 : 32'd0);
        check("pkt_final_b", 32'(pkt_b), STATS ? 32'd1 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
